// File: rtl/dut_binop_fifo_param.sv
// Address-mapped A/B -> Y binary-operator FIFO pipeline. Includes a small
// synchronous FIFO used for all three queues, plus flush and occupancy counts.

module binop_fifo_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  cnt,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Callers only push when not full and pop when not empty; flush wins over both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
endmodule

module dut_binop_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int OP_RST = 0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  output logic              write_rdy,
  input  logic [2:0]        read_address,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_rdy,
  output logic              a_full_n,
  output logic              b_full_n,
  output logic              y_empty_n
);
  typedef enum logic [1:0] {OP_OR, OP_AND, OP_XOR, OP_ADD} op_t;

  op_t               op;
  logic [1:0]        op_bits;
  logic [DATA_W-1:0] a_head, b_head, y_head, y_val;
  logic [CNT_W-1:0]  a_cnt, b_cnt, y_cnt;
  logic              a_full, b_full, y_full;
  logic              a_empty, b_empty, y_empty;
  logic              a_push, b_push, y_pop, ctrl_wr, flush, compute;

  assign a_full_n  = !a_full;
  assign b_full_n  = !b_full;
  assign y_empty_n = !y_empty;

  always_comb begin
    write_rdy = 1'b1;
    case (write_address)
      3'd4:    write_rdy = a_full_n;
      3'd5:    write_rdy = b_full_n;
      default: write_rdy = 1'b1;
    endcase
  end

  assign read_rdy = (read_address == 3'd3) ? y_empty_n : 1'b1;
  assign a_push   = write_en && write_rdy && (write_address == 3'd4);
  assign b_push   = write_en && write_rdy && (write_address == 3'd5);
  assign ctrl_wr  = write_en && (write_address == 3'd6);
  assign flush    = ctrl_wr && write_data[2];
  assign y_pop    = read_en && (read_address == 3'd3) && y_empty_n;
  assign compute  = !a_empty && !b_empty && !y_full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op <= op_t'(2'(OP_RST));
    end else if (ctrl_wr) begin
      op <= op_t'(write_data[1:0]);
    end
  end

  // ADD wraps naturally at DATA_W bits; the carry is simply dropped.
  always_comb begin
    y_val = a_head | b_head;
    case (op)
      OP_OR:   y_val = a_head | b_head;
      OP_AND:  y_val = a_head & b_head;
      OP_XOR:  y_val = a_head ^ b_head;
      OP_ADD:  y_val = a_head + b_head;
      default: y_val = a_head | b_head;
    endcase
  end

  binop_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_a (
    .clk(CLK), .rst(RST), .flush(flush), .push(a_push), .pop(compute),
    .din(write_data), .head(a_head), .cnt(a_cnt), .full(a_full), .empty(a_empty)
  );

  binop_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_b (
    .clk(CLK), .rst(RST), .flush(flush), .push(b_push), .pop(compute),
    .din(write_data), .head(b_head), .cnt(b_cnt), .full(b_full), .empty(b_empty)
  );

  binop_fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_y (
    .clk(CLK), .rst(RST), .flush(flush), .push(compute), .pop(y_pop),
    .din(y_val), .head(y_head), .cnt(y_cnt), .full(y_full), .empty(y_empty)
  );

  assign op_bits = op;

  always_comb begin
    read_data = '0;
    case (read_address)
      3'd0: read_data = DATA_W'(a_full_n);
      3'd1: read_data = DATA_W'(b_full_n);
      3'd2: read_data = DATA_W'(y_empty_n);
      3'd3: read_data = y_empty_n ? y_head : '0;
      3'd4: read_data = DATA_W'(a_cnt);
      3'd5: read_data = DATA_W'(b_cnt);
      3'd6: read_data = DATA_W'(y_cnt);
      3'd7: read_data = DATA_W'(op_bits);
      default: read_data = '0;
    endcase
  end
endmodule

// File: tb/tb_dut_binop_fifo_param.sv
// Directed bench for dut_binop_fifo_param: reset, ops, backpressure,
// flush and async reset, all against hand-computed values.

module tb_dut_binop_fifo_param;
  localparam int DATA_W = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [2:0]        write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_en;
  logic              write_rdy;
  logic [2:0]        read_address;
  logic              read_en;
  logic [DATA_W-1:0] read_data;
  logic              read_rdy;
  logic              a_full_n, b_full_n, y_empty_n;

  int checks   = 0;
  int failures = 0;

  dut_binop_fifo_param #(.DATA_W(DATA_W), .DEPTH(4), .OP_RST(0)) dut (
    .CLK(CLK), .RST(RST),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy),
    .a_full_n(a_full_n), .b_full_n(b_full_n), .y_empty_n(y_empty_n)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; holds the write for exactly one rising edge.
  task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
    write_address = addr;
    write_data    = data;
    write_en      = 1'b1;
    @(negedge CLK);
    write_en      = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    read_address = addr;
    #1;
    checkOutput(tag, read_data, exp);
  endtask

  task automatic readPop(input string tag, input logic [7:0] exp);
    read_address = 3'd3;
    #1;
    checkOutput(tag, read_data, exp);
    read_en = 1'b1;
    @(negedge CLK);
    read_en = 1'b0;
  endtask

  logic [7:0] drain_exp [7] = '{8'h10, 8'h13, 8'h12, 8'h22, 8'h23, 8'h20, 8'h21};

  initial begin
    write_en = 0; read_en = 0; write_address = 0; write_data = 0; read_address = 0;
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset values
    checkOutput("rst_a_full_n", a_full_n, 1);
    checkOutput("rst_b_full_n", b_full_n, 1);
    checkOutput("rst_y_empty_n", y_empty_n, 0);
    checkReg("rst_op", 3'd7, 8'h00);
    checkReg("rst_acnt", 3'd4, 8'h00);
    checkReg("rst_bcnt", 3'd5, 8'h00);
    checkReg("rst_ycnt", 3'd6, 8'h00);
    checkReg("rst_yhead", 3'd3, 8'h00);
    checkOutput("rst_read_rdy", read_rdy, 0);
    RST = 1'b0;
    @(negedge CLK);

    // OR path and two-edge latency
    applyStimulus(3'd4, 8'h0F);
    applyStimulus(3'd5, 8'hF0);
    checkOutput("or_y_not_yet", y_empty_n, 0);
    checkReg("or_acnt", 3'd4, 8'h01);
    @(negedge CLK);
    checkOutput("or_y_ready", y_empty_n, 1);
    readPop("or_result", 8'hFF);
    checkOutput("or_y_drained", y_empty_n, 0);

    // ADD wrap and XOR
    applyStimulus(3'd6, 8'h03);
    checkReg("add_op", 3'd7, 8'h03);
    applyStimulus(3'd4, 8'hC8);
    applyStimulus(3'd5, 8'h64);
    @(negedge CLK);
    readPop("add_wrap", 8'h2C);
    applyStimulus(3'd6, 8'h02);
    applyStimulus(3'd4, 8'hAA);
    applyStimulus(3'd5, 8'hFF);
    @(negedge CLK);
    readPop("xor_result", 8'h55);

    // Backpressure with XOR still selected
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'd4, 8'h10 + 8'(i));
      applyStimulus(3'd5, 8'h01);
    end
    repeat (2) @(negedge CLK);
    checkReg("bp_ycnt_full", 3'd6, 8'h04);
    checkReg("bp_acnt_empty", 3'd4, 8'h00);
    checkReg("bp_bcnt_empty", 3'd5, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(3'd4, 8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) applyStimulus(3'd5, 8'h02);
    checkReg("bp_acnt_full", 3'd4, 8'h04);
    checkReg("bp_bcnt_full", 3'd5, 8'h04);
    write_address = 3'd4;
    #1;
    checkOutput("bp_write_rdy_a", write_rdy, 0);
    checkOutput("bp_a_full_n", a_full_n, 0);
    write_address = 3'd6;
    #1;
    checkOutput("bp_write_rdy_ctrl", write_rdy, 1);
    applyStimulus(3'd4, 8'h77);
    checkReg("bp_acnt_ignored", 3'd4, 8'h04);
    @(negedge CLK);
    readPop("bp_pop0", 8'h11);
    checkReg("bp_ycnt_after_pop", 3'd6, 8'h03);
    checkReg("bp_acnt_no_compute", 3'd4, 8'h04);
    @(negedge CLK);
    checkReg("bp_ycnt_resumed", 3'd6, 8'h04);
    checkReg("bp_acnt_resumed", 3'd4, 8'h03);
    @(negedge CLK);
    for (int i = 0; i < 7; i++) readPop($sformatf("bp_drain%0d", i), drain_exp[i]);
    checkOutput("bp_y_empty", y_empty_n, 0);
    checkReg("bp_acnt_end", 3'd4, 8'h00);

    // Flush overrides a same-edge compute
    @(negedge CLK);
    applyStimulus(3'd6, 8'h00);
    applyStimulus(3'd4, 8'h01);
    applyStimulus(3'd5, 8'h02);
    applyStimulus(3'd4, 8'h04);
    applyStimulus(3'd5, 8'h08);
    for (int i = 0; i < 3; i++) applyStimulus(3'd4, 8'h40);
    applyStimulus(3'd5, 8'h80);
    checkReg("fl_acnt_pre", 3'd4, 8'h03);
    checkReg("fl_bcnt_pre", 3'd5, 8'h01);
    checkReg("fl_ycnt_pre", 3'd6, 8'h02);
    applyStimulus(3'd6, 8'h04);
    checkReg("fl_acnt", 3'd4, 8'h00);
    checkReg("fl_bcnt", 3'd5, 8'h00);
    checkReg("fl_ycnt", 3'd6, 8'h00);
    checkOutput("fl_y_empty_n", y_empty_n, 0);
    checkReg("fl_op", 3'd7, 8'h00);
    applyStimulus(3'd4, 8'h30);
    applyStimulus(3'd5, 8'h03);
    @(negedge CLK);
    readPop("fl_after", 8'h33);

    // Async reset mid-stream
    applyStimulus(3'd6, 8'h03);
    applyStimulus(3'd4, 8'h01);
    applyStimulus(3'd5, 8'h02);
    applyStimulus(3'd4, 8'h03);
    applyStimulus(3'd5, 8'h04);
    @(negedge CLK);
    checkReg("ar_ycnt_pre", 3'd6, 8'h02);
    read_en = 1'b1;
    @(negedge CLK);
    read_en = 1'b0;
    checkReg("ar_ycnt_side_read", 3'd6, 8'h02);
    checkReg("ar_yhead_pre", 3'd3, 8'h03);
    @(negedge CLK);
    applyStimulus(3'd4, 8'h09);
    #1 RST = 1'b1;
    #1;
    checkOutput("ar_y_empty_n", y_empty_n, 0);
    checkOutput("ar_a_full_n", a_full_n, 1);
    checkReg("ar_yhead", 3'd3, 8'h00);
    checkReg("ar_op", 3'd7, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checkReg("ar_ycnt_post", 3'd6, 8'h00);
    checkReg("ar_acnt_post", 3'd4, 8'h00);
    checkReg("ar_op_post", 3'd7, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
